// File: rtl/score_board.sv
// High-score table: ENTRIES slots kept sorted by score (descending), filled by a
// serial scan-then-insert engine, with a registered view port for a display mux.
module score_board #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] user_id,
  input  logic [15:0] score_in,
  input  logic        score_load,
  input  logic        view_next,
  input  logic        clear,
  output logic [31:0] scores_out,
  output logic [2:0]  view_index,
  output logic        busy,
  output logic        new_high,
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    INSERT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          p_q, p_d;
  logic [2:0]          view_q, view_d;
  logic [15:0]         lat_id_q, lat_id_d;
  logic [15:0]         lat_score_q, lat_score_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [15:0]         id_q [ENTRIES];
  logic [15:0]         id_d [ENTRIES];
  logic [15:0]         sc_q [ENTRIES];
  logic [15:0]         sc_d [ENTRIES];
  logic [31:0]         scores_out_q, scores_out_d;

  logic                cur_valid;
  logic [15:0]         cur_score;
  logic                match;
  logic                last_slot;

  // Slot under the scan pointer, and the slot under the view pointer.
  always_comb begin
    cur_valid    = 1'b0;
    cur_score    = '0;
    scores_out_d = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      if (p_q == 3'(k)) begin
        cur_valid = valid_q[k];
        cur_score = sc_q[k];
      end
      if (view_q == 3'(k) && valid_q[k]) begin
        scores_out_d = {id_q[k], sc_q[k]};
      end
    end
  end

  // Strictly-greater keeps an older equal score ahead of the newcomer.
  assign match     = !cur_valid || (lat_score_q > cur_score);
  assign last_slot = (p_q == 3'(ENTRIES - 1));

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    view_d      = view_q;
    lat_id_d    = lat_id_q;
    lat_score_d = lat_score_q;
    valid_d     = valid_q;
    id_d        = id_q;
    sc_d        = sc_q;

    case (state_q)
      IDLE: begin
        if (score_load) begin
          lat_id_d    = user_id;
          lat_score_d = score_in;
          p_d         = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          state_d = INSERT;
        end else if (last_slot) begin
          state_d = IDLE;
        end else begin
          p_d = p_q + 3'd1;
        end
      end
      INSERT: begin
        state_d = IDLE;
        for (int k = 1; k < ENTRIES; k++) begin
          if (3'(k) > p_q) begin
            valid_d[k] = valid_q[k-1];
            id_d[k]    = id_q[k-1];
            sc_d[k]    = sc_q[k-1];
          end
        end
        for (int k = 0; k < ENTRIES; k++) begin
          if (p_q == 3'(k)) begin
            valid_d[k] = 1'b1;
            id_d[k]    = lat_id_q;
            sc_d[k]    = lat_score_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (view_next) begin
      view_d = (view_q == 3'(ENTRIES - 1)) ? 3'd0 : view_q + 3'd1;
    end

    // Clear wins over any submission in flight and over view_next.
    if (clear) begin
      state_d = IDLE;
      p_d     = '0;
      valid_d = '0;
      view_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      p_q          <= '0;
      view_q       <= '0;
      lat_id_q     <= '0;
      lat_score_q  <= '0;
      valid_q      <= '0;
      scores_out_q <= '0;
      for (int k = 0; k < ENTRIES; k++) begin
        id_q[k] <= '0;
        sc_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      view_q       <= view_d;
      lat_id_q     <= lat_id_d;
      lat_score_q  <= lat_score_d;
      valid_q      <= valid_d;
      scores_out_q <= scores_out_d;
      id_q         <= id_d;
      sc_q         <= sc_d;
    end
  end

  assign scores_out  = scores_out_q;
  assign view_index  = view_q;
  assign busy        = (state_q != IDLE);
  assign new_high    = (state_q == INSERT) && (p_q == 3'd0);
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_score_board.sv
// Directed bench for score_board: table of submissions with hand-computed table
// contents, plus hand-written sequences for busy-loads, clear, view and reset.
module tb_score_board;

  localparam int ENTRIES = 4;

  logic        clk;
  logic        rst;
  logic [15:0] user_id;
  logic [15:0] score_in;
  logic        score_load;
  logic        view_next;
  logic        clear;
  logic [31:0] scores_out;
  logic [2:0]  view_index;
  logic        busy;
  logic        new_high;
  logic [1:0]  fsm_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  score_board #(.ENTRIES(ENTRIES)) dut (
    .clk        (clk),
    .rst        (rst),
    .user_id    (user_id),
    .score_in   (score_in),
    .score_load (score_load),
    .view_next  (view_next),
    .clear      (clear),
    .scores_out (scores_out),
    .view_index (view_index),
    .busy       (busy),
    .new_high   (new_high),
    .fsm_state_o(fsm_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks (all drive at the falling edge)
  task automatic submit(input logic [15:0] id, input logic [15:0] sc,
                        output int busy_cycles, output int nh_pulses);
    user_id    = id;
    score_in   = sc;
    score_load = 1'b1;
    @(negedge clk);
    score_load = 1'b0;
    busy_cycles = 0;
    nh_pulses   = 0;
    while (busy && busy_cycles < 20) begin
      if (new_high) nh_pulses++;
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(busy), 32'h0);
  endtask

  // Walks view 0..ENTRIES-1 and back to 0; expects view_index == 0 on entry.
  task automatic read_slots(input string name, input logic [3:0][31:0] exp_tab);
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      chk($sformatf("%s view_index %0d", name, i), 32'(view_index), 32'(i));
      chk($sformatf("%s slot %0d", name, i), scores_out, exp_tab[i]);
      view_next = 1'b1;
      @(negedge clk);
      view_next = 1'b0;
    end
  endtask

  typedef struct {
    logic [15:0]      id;
    logic [15:0]      score;
    int               exp_busy;
    int               exp_nh;
    logic [3:0][31:0] exp_tab;
  } load_vec_t;

  typedef struct {
    logic [2:0]  exp_idx;
    logic [31:0] exp_data;
  } view_vec_t;

  load_vec_t vecs [8];
  view_vec_t vsteps [4];

  initial begin
    int bc, nh;
    logic [31:0] prev;

    vecs[0] = '{16'h0A01, 16'd100, 2, 1, {32'h0, 32'h0, 32'h0, 32'h0A01_0064}};
    vecs[1] = '{16'h0B02, 16'd200, 2, 1, {32'h0, 32'h0, 32'h0A01_0064, 32'h0B02_00C8}};
    vecs[2] = '{16'h0C03, 16'd400, 2, 1, {32'h0, 32'h0A01_0064, 32'h0B02_00C8, 32'h0C03_0190}};
    vecs[3] = '{16'h0D04, 16'd300, 3, 0, {32'h0A01_0064, 32'h0B02_00C8, 32'h0D04_012C, 32'h0C03_0190}};
    vecs[4] = '{16'h0F06, 16'd50,  4, 0, {32'h0A01_0064, 32'h0B02_00C8, 32'h0D04_012C, 32'h0C03_0190}};
    vecs[5] = '{16'h0E05, 16'd250, 4, 0, {32'h0B02_00C8, 32'h0E05_00FA, 32'h0D04_012C, 32'h0C03_0190}};
    vecs[6] = '{16'h0A07, 16'd300, 4, 0, {32'h0E05_00FA, 32'h0A07_012C, 32'h0D04_012C, 32'h0C03_0190}};
    vecs[7] = '{16'h0B08, 16'd500, 2, 1, {32'h0A07_012C, 32'h0D04_012C, 32'h0C03_0190, 32'h0B08_01F4}};

    vsteps[0] = '{3'd1, 32'h0F0C_0021};
    vsteps[1] = '{3'd2, 32'h0};
    vsteps[2] = '{3'd3, 32'h0};
    vsteps[3] = '{3'd0, 32'h0E0B_004D};

    rst = 1'b1; user_id = '0; score_in = '0;
    score_load = 1'b0; view_next = 1'b0; clear = 1'b0;
    #3;
    chk("reset scores_out", scores_out, 32'h0);
    chk("reset view_index", 32'(view_index), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset new_high", 32'(new_high), 32'h0);
    chk("reset state", 32'(fsm_state_o), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven submissions from an empty table
    for (int v = 0; v < 8; v++) begin
      submit(vecs[v].id, vecs[v].score, bc, nh);
      chk($sformatf("vec%0d busy cycles", v), 32'(bc), 32'(vecs[v].exp_busy));
      chk($sformatf("vec%0d new_high pulses", v), 32'(nh), 32'(vecs[v].exp_nh));
      read_slots($sformatf("vec%0d", v), vecs[v].exp_tab);
    end

    // Load while busy is dropped; the first load scans the full table and is discarded
    user_id = 16'h0C09; score_in = 16'd10; score_load = 1'b1;
    @(negedge clk);
    user_id = 16'h0D0A; score_in = 16'd700;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
      score_load = 1'b0;
    end
    score_load = 1'b0;
    chk("busy-load busy cycles", 32'(bc), 32'd4);
    read_slots("busy-load", vecs[7].exp_tab);

    // Clear mid-SCAN with a simultaneous load
    user_id = 16'h0C09; score_in = 16'd10; score_load = 1'b1;
    @(negedge clk);
    chk("clear pre busy", 32'(busy), 32'h1);
    user_id = 16'h1111; score_in = 16'd999; clear = 1'b1;
    @(negedge clk);
    score_load = 1'b0; clear = 1'b0;
    chk("clear busy", 32'(busy), 32'h0);
    chk("clear view_index", 32'(view_index), 32'h0);
    read_slots("clear", '0);
    chk("clear load ignored", 32'(busy), 32'h0);

    // Simultaneous view_next and score_load
    user_id = 16'h0E0B; score_in = 16'd77; score_load = 1'b1; view_next = 1'b1;
    @(negedge clk);
    score_load = 1'b0; view_next = 1'b0;
    chk("simul view_index", 32'(view_index), 32'h1);
    chk("simul busy", 32'(busy), 32'h1);
    wait_idle("simul idle");
    submit(16'h0F0C, 16'd33, bc, nh);
    chk("second entry busy cycles", 32'(bc), 32'd3);
    for (int i = 0; i < 3; i++) begin
      view_next = 1'b1;
      @(negedge clk);
      view_next = 1'b0;
    end
    chk("view back to 0", 32'(view_index), 32'h0);
    @(negedge clk);

    // View stepping with one cycle of output lag
    prev = 32'h0E0B_004D;
    for (int s = 0; s < 4; s++) begin
      view_next = 1'b1;
      @(negedge clk);
      view_next = 1'b0;
      chk($sformatf("step%0d view_index", s), 32'(view_index), 32'(vsteps[s].exp_idx));
      chk($sformatf("step%0d lag", s), scores_out, prev);
      @(negedge clk);
      chk($sformatf("step%0d scores_out", s), scores_out, vsteps[s].exp_data);
      prev = vsteps[s].exp_data;
    end

    // Asynchronous reset in the middle of an INSERT cycle
    user_id = 16'h0A0D; score_in = 16'd900; score_load = 1'b1; view_next = 1'b1;
    @(negedge clk);
    score_load = 1'b0; view_next = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-rst new_high", 32'(new_high), 32'h1);
    chk("pre-rst scores_out", scores_out, 32'h0F0C_0021);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst scores_out", scores_out, 32'h0);
    chk("async rst view_index", 32'(view_index), 32'h0);
    chk("async rst busy", 32'(busy), 32'h0);
    chk("async rst new_high", 32'(new_high), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    read_slots("post-rst", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_board.md
SCORE_BOARD -- requirements
Module: score_board

Interface
REQ-001 Parameter ENTRIES, default 4, number of high-score slots; legal values 2..8.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 user_id  input  16  ID of the player whose game just ended; sampled with score_load.
REQ-005 score_in  input  16  final game score, unsigned; sampled with score_load.
REQ-006 score_load  input  1  one-cycle pulse from the game block: submit {user_id, score_in}.
REQ-007 view_next  input  1  one-cycle shaped-button pulse: advance the displayed slot.
REQ-008 clear  input  1  one-cycle pulse from process control: erase the table.
REQ-009 scores_out  output  32  {id[15:0], score[15:0]} of the displayed slot; feeds the 7-segment display mux.
REQ-010 view_index  output  3  index of the displayed slot; 0 = best.
REQ-011 busy  output  1  high while a submission is being processed.
REQ-012 new_high  output  1  one-cycle pulse when a submission lands in slot 0.

Function
REQ-013 The table shall hold ENTRIES slots, each with {valid, id[15:0], score[15:0]}.
REQ-014 Valid slots shall be contiguous from slot 0 and sorted by score, descending.
REQ-015 The FSM shall have states IDLE, SCAN, INSERT.
- IDLE -> SCAN on score_load.
- SCAN -> INSERT on a match.
- SCAN -> IDLE on no match.
- INSERT -> IDLE always.
REQ-016 In IDLE, score_load shall latch user_id and score_in and set scan pointer p=0.
REQ-017 SCAN shall examine one slot per cycle, starting at slot 0.
- Slot p matches if it is invalid, or if the latched score is strictly greater than slot p's score.
- On a match, insert position = p.
- On no match, p increments.
- After slot ENTRIES-1 fails to match, the submission is discarded and the FSM returns to IDLE.
REQ-018 Ties shall rank the older entry ahead of the newer one.
REQ-019 INSERT shall take one cycle.
- Slots k = ENTRIES-1 down to pos+1 receive slot k-1.
- Slot pos receives {1, latched id, latched score}.
- The previous content of slot ENTRIES-1 is lost.
REQ-020 new_high shall be high for exactly the INSERT cycle when pos = 0, and low otherwise.
REQ-021 busy shall be high in SCAN and INSERT and low in IDLE.
- A submission loaded at edge t raises busy from t+1.
- Total latency is p_final+2 cycles.
REQ-022 score_load while busy shall be ignored; no queueing.
REQ-023 view_next shall advance view_index by 1, wrapping from ENTRIES-1 to 0.
- view_next is accepted in any state.
REQ-024 scores_out shall be registered.
- It reflects slot view_index as of the previous edge, i.e. one cycle of latency after a table or index change.
- It is 32'h0 when that slot is invalid.
REQ-025 clear shall have priority over everything else.
- On the next edge: all valid bits = 0, FSM = IDLE, busy = 0, view_index = 0.
- Any submission in progress is aborted.
- A score_load in the same cycle as clear is ignored.
REQ-026 Simultaneous view_next and score_load shall both take effect.
REQ-027 Score and ID arithmetic shall be unsigned 16-bit comparisons only; no accumulation, no overflow cases.

Reset
REQ-028 rst high shall immediately force:
- all valid bits = 0, FSM = IDLE, view_index = 0;
- scores_out = 32'h0, busy = 0, new_high = 0;
- latched id and score = 0.
REQ-029 Operation shall resume on the first rising edge after rst falls.
REQ-030 rst asserted mid-SCAN or mid-INSERT shall discard the submission with no partial table write.

Verification
REQ-031 Empty table; load (id 16'h0A01, score 100):
- busy high 2 cycles, new_high pulses once;
- scores_out = 32'h0A01_0064 two cycles after busy falls.
REQ-032 Fill the table with scores 400, 300, 200, 100; load 250:
- SCAN takes 3 cycles;
- table becomes 400, 300, 250, 200;
- 100 is dropped; new_high stays 0.
REQ-033 Full table 400..100; load 50:
- busy for exactly ENTRIES cycles;
- table unchanged; new_high 0.
REQ-034 Tie case: slot 1 holds 300 from id A; load 300 from id B:
- B lands at slot 2, behind A.
REQ-035 Clear and ignored loads:
- Assert clear during SCAN: busy 0 next cycle and all slots read 32'h0.
- A score_load pulsed while busy causes no table change.
REQ-036 Four view_next pulses with ENTRIES=4:
- view_index steps 1, 2, 3, 0;
- scores_out follows one cycle later each time.
- Then assert rst asynchronously mid-cycle: outputs drop to 0 before the next edge.
